// File: rtl/systolic_collector.sv
// Collects a 4x4 result matrix from skewed systolic column streams and drains it row by row.
// Optional protocol-error detection is compiled in with SYSTOLIC_COLLECTOR_ERR_EN.
module systolic_collector #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  output logic [DATA_WIDTH-1:0] out_c0,
  output logic [DATA_WIDTH-1:0] out_c1,
  output logic [DATA_WIDTH-1:0] out_c2,
  output logic [DATA_WIDTH-1:0] out_c3,
  output logic [1:0]            out_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [2:0]            beat_q, beat_d;
  logic [1:0]            row_q, row_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mat_q [16];
  logic [DATA_WIDTH-1:0] mat_d [16];
  logic [DATA_WIDTH-1:0] in_arr [4];

  always_comb begin
    in_arr[0] = in0;
    in_arr[1] = in1;
    in_arr[2] = in2;
    in_arr[3] = in3;
    state_d   = state_q;
    beat_d    = beat_q;
    row_d     = row_q;
    done_d    = 1'b0;
    mat_d     = mat_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (in_valid) begin
          // Beat s carries C[s-j][j] on column port j; matrix index is {row, col}.
          for (int unsigned j = 0; j < 4; j++) begin
            if ((beat_q >= 3'(j)) && ((beat_q - 3'(j)) <= 3'd3))
              mat_d[{2'(beat_q - 3'(j)), 2'(j)}] = in_arr[2'(j)];
          end
          if (beat_q == 3'd6) begin
            state_d = DRAIN;
            beat_d  = '0;
            row_d   = '0;
          end else begin
            state_d = COLLECT;
            beat_d  = beat_q + 3'd1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == 2'd3) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) mat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      done_q  <= done_d;
      mat_q   <= mat_d;
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_row   = out_valid ? row_q : '0;
  assign out_c0    = out_valid ? mat_q[{row_q, 2'd0}] : '0;
  assign out_c1    = out_valid ? mat_q[{row_q, 2'd1}] : '0;
  assign out_c2    = out_valid ? mat_q[{row_q, 2'd2}] : '0;
  assign out_c3    = out_valid ? mat_q[{row_q, 2'd3}] : '0;

`ifdef SYSTOLIC_COLLECTOR_ERR_EN
  logic err_q, err_d;

  // Any beat while draining is a violation, including the cycle that accepts row 3.
  always_comb begin
    err_d = err_q | (in_valid && (state_q == DRAIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_collector.sv
// Bench for systolic_collector: scoreboard of expected rows plus directed scenarios.
module tb_systolic_collector;

`ifdef SYSTOLIC_COLLECTOR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in0, in1, in2, in3;
  logic [31:0] out_c0, out_c1, out_c2, out_c3;
  logic [1:0]  out_row;
  logic        out_valid, out_ready, busy, done, err;

  systolic_collector #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2), .out_c3(out_c3),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       row;
    logic [3:0][31:0] c;
  } row_t;

  row_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  bit   exp_done_nxt = 1'b0;
  bit   exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cval(input logic [7:0] base, input int r, input int j);
    return 32'(base) + 32'(4 * r + j);
  endfunction

  function automatic logic [31:0] beatval(input logic [7:0] base, input int s, input int j);
    if (s >= j && s - j <= 3) return cval(base, s - j, j);
    return 32'd0;
  endfunction

  task automatic push_matrix(input logic [7:0] base);
    for (int r = 0; r < 4; r++) begin
      row_t e;
      e.row = 2'(r);
      for (int j = 0; j < 4; j++) e.c[j] = cval(base, r, j);
      q.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
  endtask

  task automatic feed(input logic [7:0] base, input int nbeats, input int gap2, input int gap5);
    for (int s = 0; s < nbeats; s++) begin
      in_valid = 1'b1;
      in0 = beatval(base, s, 0);
      in1 = beatval(base, s, 1);
      in2 = beatval(base, s, 2);
      in3 = beatval(base, s, 3);
      if (s == 6) push_matrix(base);
      @(posedge clk); #1;
      idle_inputs();
      if (s == 2) repeat (gap2) begin @(posedge clk); #1; end
      if (s == 5) repeat (gap5) begin @(posedge clk); #1; end
      if (s == 6) begin
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_row", 64'(out_row), 64'd0);
      end
    end
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; break; end
    end
    chk("done_timeout", 64'(got), 64'd1);
  endtask

  // Scoreboard: every visible row must match the queue head, zeros otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done", 64'(done), 64'(exp_done_nxt));
      if (done) done_cnt++;
      exp_done_nxt = 1'b0;
      chk("err", 64'(err), 64'(exp_err));
      if (out_valid) begin
        chk("busy_in_drain", 64'(busy), 64'd1);
        if (q.size() == 0) begin
          chk("unexpected_row", 64'(out_valid), 64'd0);
        end else begin
          chk("row_idx", 64'(out_row), 64'(q[0].row));
          chk("c0", 64'(out_c0), 64'(q[0].c[0]));
          chk("c1", 64'(out_c1), 64'(q[0].c[1]));
          chk("c2", 64'(out_c2), 64'(q[0].c[2]));
          chk("c3", 64'(out_c3), 64'(q[0].c[3]));
          if (out_ready) begin
            if (q[0].row == 2'd3) exp_done_nxt = 1'b1;
            void'(q.pop_front());
          end
        end
        if (in_valid && ERR_EN) exp_err = 1'b1;
      end else begin
        chk("zero_when_idle", {out_c0, out_c1}, 64'd0);
        chk("zero_when_idle_hi", {out_c2, out_c3}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_row", 64'(out_row), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic collect and drain with literal row contents.
    feed(8'h01, 7, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_row", 64'(out_row), 64'(k));
      chk("t1_c0", 64'(out_c0), 64'(4 * k + 1));
      chk("t1_c3", 64'(out_c3), 64'(4 * k + 4));
      @(posedge clk); #1;
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_valid_low", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 64'(done), 64'd0);

    // Gapped input.
    feed(8'h01, 7, 2, 2);
    wait_done();

    // Backpressure on row 1.
    feed(8'h01, 7, 0, 0);
    @(posedge clk); #1;
    chk("bp_row", 64'(out_row), 64'd1);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_row", 64'(out_row), 64'd1);
      chk("bp_hold_c", {out_c0[7:0], out_c1[7:0], out_c2[7:0], out_c3[7:0]}, 64'h05060708);
    end
    out_ready = 1'b1;
    wait_done();

    // Back-to-back: second beat 0 in the done cycle.
    feed(8'h31, 7, 0, 0);
    wait_done();
    feed(8'h41, 7, 0, 0);
    wait_done();

    // Protocol error: beat during drain.
    feed(8'h51, 7, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in0 = 32'hDEAD0000; in1 = 32'hDEAD0001; in2 = 32'hDEAD0002; in3 = 32'hDEAD0003;
    @(posedge clk); #1;
    idle_inputs();
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'(err), 64'(ERR_EN));

    // Reset mid-collect, then a fresh matrix.
    feed(8'h61, 4, 0, 0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_done_nxt = 1'b0;
    exp_err = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_c", {out_c0, out_c3}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    feed(8'h11, 7, 0, 0);
    chk("rst_new_row0", {out_c0[7:0], out_c1[7:0], out_c2[7:0], out_c3[7:0]}, 64'h11121314);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_collector.md
SYSTOLIC_COLLECTOR -- requirements
Module: systolic_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each result element.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: one skewed result beat is present this cycle.
REQ-005 SHALL have ports in0..in3, input, DATA_WIDTH each: skewed column streams; port j carries column j.
REQ-006 SHALL have ports out_c0..out_c3, output, DATA_WIDTH each: columns 0..3 of the presented result row.
REQ-007 SHALL have port out_row, output, 2: index of the presented row.
REQ-008 SHALL have port out_valid, output, 1: out_c*/out_row hold a row.
REQ-009 SHALL have port out_ready, input, 1: the downstream consumer accepts the row.
REQ-010 SHALL have port busy, output, 1: high in COLLECT and DRAIN.
REQ-011 SHALL have port done, output, 1: one-cycle pulse after the last row is accepted.
REQ-012 SHALL have port err, output, 1: sticky protocol-error flag (see REQ-025).

Function
REQ-013 SHALL implement the FSM IDLE -> COLLECT -> DRAIN -> IDLE.
- IDLE: a cycle with in_valid high is beat 0 and enters COLLECT.
REQ-014 SHALL count accepted beats s = 0..6 with a 3-bit counter that increments only on cycles where in_valid is high.
- in_valid gaps in COLLECT are allowed; the state and counter hold.
REQ-015 SHALL, on beat s, store in[j] as C[s-j][j] for each j with 0 <= s-j <= 3.
- All other port values on that beat are ignored.
REQ-016 SHALL enter DRAIN in the cycle after beat 6 is accepted.
- In that cycle out_valid = 1, out_row = 0, and out_c0..3 = C[0][0..3].
REQ-017 SHALL advance out_row by one on every cycle where out_valid and out_ready are both high.
- While out_ready is low, out_c*/out_row SHALL hold stable.
REQ-018 SHALL, when row 3 is accepted, go to IDLE and drive out_valid = 0 and done = 1 for exactly the next cycle.
REQ-019 SHALL accept in_valid in the done cycle as beat 0 of the next matrix, so operations can run back-to-back.
REQ-020 SHALL ignore in_valid during DRAIN: no capture and no state change.
REQ-021 SHALL have latency from beat 6 to the first out_valid of exactly 1 cycle.
REQ-022 SHALL drive out_c0..3 to zero whenever out_valid is low.
REQ-023 SHALL retain the stored matrix values until the next beat 0 overwrites them.

Reset
REQ-024 SHALL, while rst_n is low, immediately and asynchronously:
- put the FSM in IDLE;
- clear the beat and row counters, the stored matrix and err;
- drive out_valid, busy, done, out_row and out_c0..3 to 0.
- Reset mid-COLLECT or mid-DRAIN SHALL discard the partial matrix.

Configuration
REQ-025 SHALL use the macro SYSTOLIC_COLLECTOR_ERR_EN.
- Defined: err is set and held on in_valid during DRAIN, or on in_valid in the same cycle that out_valid&&out_ready accepts row 3; it is cleared only by reset.
- Not defined: err is tied to 0 and no detection logic is present.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-026 Basic collect and drain:
- Stimulus: C = 0x01..0x10 row-major (C[r][j] = 4r+j+1), fed as 7 contiguous skewed beats with zeros on unused ports; out_ready = 1.
- Response: rows out in order 01 02 03 04 / 05 06 07 08 / 09 0A 0B 0C / 0D 0E 0F 10 on 4 consecutive cycles, then done high for 1 cycle.
REQ-027 Gapped input:
- Stimulus: same stream with in_valid low for 2 cycles after beats 2 and 5.
- Response: identical rows; first out_valid exactly 1 cycle after beat 6.
REQ-028 Backpressure:
- Stimulus: out_ready low for 3 cycles while row 1 is presented.
- Response: out_row = 1 and 05 06 07 08 held stable; no row skipped; done exactly once.
REQ-029 Reset mid-operation:
- Stimulus: rst_n low after beat 3, then a full stream of C = 0x11..0x20.
- Response: all outputs 0 during reset; drained rows equal the new matrix, first row 11 12 13 14.
REQ-030 Back-to-back:
- Stimulus: a second matrix's beat 0 applied in the done cycle.
- Response: second matrix drained correctly; done pulses twice in total.
REQ-031 Protocol error:
- Stimulus: in_valid pulsed during DRAIN.
- Response, macro defined: err = 1 and stays 1 until reset.
- Response, macro undefined: err = 0.
- Response, both builds: drained data is unchanged.
